counter8: RTL and testbench
===========================

# counter8

Free-running 3-bit binary up-counter with an integrated seven-segment decoder. Counts 0 to 7 on every rising clock edge and wraps, presenting both the raw count and the matching digit pattern for a single seven-segment display. Sits at board level, between the system clock/reset and one display digit; used as a basic counting and display demonstrator.

## Interface
- `SEG_ACTIVE_LOW`, default 1: 1 means a lit segment is driven 0 (common-anode); 0 means a lit segment is driven 1.
- `CLK`  input  1  system clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-high (asserted = 1, despite the name); sampled on the rising edge of `CLK`.
- `oQ`  output  3  current count value, unsigned 0..7.
- `oDisplay`  output  7  seven-segment pattern for `oQ`; bit order `oDisplay[0]`=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.

## Operation
- The count register is 3 bits and drives `oQ` directly.
- Each rising edge with `rst_n`=1: count is set to 0.
- Each rising edge with `rst_n`=0: count is incremented by 1, modulo 8.
- No enable input; the counter is free-running whenever reset is deasserted.
- `oDisplay` is a pure combinational decode of the count register; there is no extra pipeline register.
- Active-high segment patterns, written as hex of bits g..a:
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F
  - 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07
- With `SEG_ACTIVE_LOW`=1 the output is the bitwise inverse of these patterns:
  - 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30
  - 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78
- The decoder covers all 8 input codes, so there is no default or blank case.

## Timing
- Reset value: `oQ`=0 and `oDisplay`=digit 0 (0x40 at the default parameter), valid from the first edge that samples `rst_n`=1.
- Before the first reset, the register contents are undefined. The bench must apply reset before checking outputs.
- Increment latency: 1 cycle. `oQ` changes only just after a rising edge.
- `oDisplay` settles combinationally in the same cycle as `oQ`.
- Wrap-around: 7 goes to 0 on the next edge, with no flag and no stall.
- Reset mid-count: the next edge forces 0 whatever the current value. Reset takes priority over the increment.
- Reset held for N edges: `oQ` stays 0 throughout.
- On the first edge after release, `oQ` becomes 1.
- Glitches on `rst_n` between clock edges have no effect.

## Structure
- Shared package `counter8_pkg` holds:
  - the 8 active-high segment constants (`SEG_0`..`SEG_7`);
  - the count width localparam (3).
- Sub-module `seg7_decoder`:
  - input: 3-bit value plus the `SEG_ACTIVE_LOW` parameter;
  - output: 7-bit pattern;
  - purely combinational, reusable for other digits.
- The top level contains only the count register and one `seg7_decoder` instance.

## Test plan
- Reset: hold `rst_n`=1 for 2 edges -> `oQ`=0, `oDisplay`=0x40.
- Count sequence: release reset and apply 7 edges -> `oQ` steps 1,2,…,7 and `oDisplay` steps 0x79,0x24,0x30,0x19,0x12,0x02,0x78.
- Wrap: from `oQ`=7, one edge -> `oQ`=0, `oDisplay`=0x40; the next edge gives 1.
- Reset mid-operation: at `oQ`=3, assert `rst_n` between edges -> `oQ` holds 3 until the next edge, then becomes 0 and stays 0 while asserted.
- Periodic reset: 100 ns clock, with `rst_n` toggling every 200 ns -> `oQ` cycles only 0,1,2 between resets, and never exceeds 2.
- Polarity: `SEG_ACTIVE_LOW`=0, count 0..7 -> `oDisplay` = 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07.

Source files
------------

// File: rtl/counter8_pkg.sv
// counter8_pkg: shared count width and active-high seven-segment digit patterns
package counter8_pkg;
    localparam int CNT_W = 3;
    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational 3-bit value to seven-segment pattern, bit 0 = a .. bit 6 = g
module seg7_decoder
    import counter8_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic [CNT_W-1:0] value,
    output logic [6:0]       seg
);
    logic [6:0] seg_hi;
    always_comb begin
        seg_hi = SEG_0;
        unique case (value)
            3'd0: seg_hi = SEG_0;
            3'd1: seg_hi = SEG_1;
            3'd2: seg_hi = SEG_2;
            3'd3: seg_hi = SEG_3;
            3'd4: seg_hi = SEG_4;
            3'd5: seg_hi = SEG_5;
            3'd6: seg_hi = SEG_6;
            3'd7: seg_hi = SEG_7;
        endcase
    end
    // common-anode displays light a segment by pulling it low
    assign seg = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
endmodule

// File: rtl/counter8.sv
// counter8: free-running 3-bit up-counter driving one seven-segment digit
module counter8
    import counter8_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic             CLK,
    input  logic             rst_n,
    output logic [CNT_W-1:0] oQ,
    output logic [6:0]       oDisplay
);
    // rst_n is active-high despite its name
    always_ff @(posedge CLK)
        oQ <= rst_n ? '0 : oQ + CNT_W'(1);

    seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_dec (
        .value(oQ),
        .seg  (oDisplay)
    );
endmodule

// File: tb/tb_counter8.sv
// tb_counter8: scoreboard bench for counter8 at both segment polarities
`timescale 1ns/1ps
module tb_counter8;
    logic       clk;
    logic       rst_n;
    logic [2:0] q_lo, q_hi;
    logic [6:0] disp_lo, disp_hi;
    int         total = 0;
    int         bad = 0;
    int         exp_q[$];
    logic [6:0] tbl_lo [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    logic [6:0] tbl_hi [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

    counter8 dut_lo (.CLK(clk), .rst_n(rst_n), .oQ(q_lo), .oDisplay(disp_lo));
    counter8 #(.SEG_ACTIVE_LOW(1'b0)) dut_hi (.CLK(clk), .rst_n(rst_n), .oQ(q_hi), .oDisplay(disp_hi));

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one expected count per sampled edge, checked mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            automatic int e = exp_q.pop_front();
            check("q_lo", {4'd0, q_lo}, 7'(e));
            check("q_hi", {4'd0, q_hi}, 7'(e));
            check("disp_lo", disp_lo, tbl_lo[e]);
            check("disp_hi", disp_hi, tbl_hi[e]);
        end
    end

    task automatic cyc(input logic r, input int e);
        rst_n = r;
        @(posedge clk);
        exp_q.push_back(e);
        #10;
    endtask

    initial begin
        rst_n = 1'b1;
        cyc(1, 0);
        cyc(1, 0);
        for (int i = 1; i < 8; i++) cyc(0, i);
        cyc(0, 0);
        cyc(0, 1);
        cyc(0, 2);
        cyc(0, 3);
        rst_n = 1'b1;
        #20;
        check("hold_before_edge", {4'd0, q_lo}, 7'd3);
        cyc(1, 0);
        cyc(1, 0);
        cyc(1, 0);
        cyc(0, 1);
        cyc(0, 2);
        rst_n = 1'b1;
        #5;
        rst_n = 1'b0;
        cyc(0, 3);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0);
            cyc(1, 0);
            cyc(0, 1);
            cyc(0, 2);
        end
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
